// File: rtl/mux_scan_sequencer_if.sv
// Handshake and mux-select bundle between the scan sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the mux/consumer side.
interface mux_scan_sequencer_if #(
  parameter int unsigned NUM_CH = 20,
  parameter int unsigned SEL_W  = 5
);
  logic              start;
  logic              continuous;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_in;
  logic [NUM_CH-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic              busy;

  modport master (
    input  start, continuous, mux_in, frame_ready,
    output mux_sel, frame_data, frame_valid, busy
  );

  modport slave (
    output start, continuous, mux_in, frame_ready,
    input  mux_sel, frame_data, frame_valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an NUM_CH-to-1 select mux: walks the select bus, holds each
// channel for SETTLE cycles, samples the mux output once, and hands the packed frame
// out on a valid/ready register. Backpressure stalls the scan in DELIVER.
module mux_scan_sequencer #(
  parameter int unsigned NUM_CH = 20,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned SETTLE = 2
) (
  input logic                  clk,
  input logic                  reset,
  mux_scan_sequencer_if.master bus
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              load_ok;

  // Output register can take a new frame when empty or being drained this cycle.
  assign load_ok = !frame_valid_q || bus.frame_ready;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Next-state, select walk, capture and output-register handshake.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;

    // Consumer drain; a load in DELIVER below overrides this (load wins).
    if (frame_valid_q && bus.frame_ready) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SAMPLE: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (sel_q == SEL_W'(k)) begin
            shadow_d[k] = bus.mux_in;
          end
        end
        if (sel_q == SEL_LAST) begin
          state_d = S_DELIVER;
        end else begin
          state_d = S_SETTLE;
          sel_d   = sel_q + 1'b1;
          cnt_d   = '0;
        end
      end

      S_DELIVER: begin
        if (load_ok) begin
          frame_data_d  = shadow_q;
          frame_valid_d = 1'b1;
          if (bus.continuous) begin
            state_d = S_SETTLE;
            sel_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mux_sel     = sel_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: default 20-channel instance plus a
// 5-channel SETTLE=1 instance, each fed by a behavioural select-mux model.
module tb_mux_scan_sequencer;

  logic clk;
  logic reset;

  int unsigned errors;
  int unsigned checks;

  logic [19:0] sig_big;
  logic [4:0]  sig_small;

  mux_scan_sequencer_if #(.NUM_CH(20), .SEL_W(5)) big_if ();
  mux_scan_sequencer_if #(.NUM_CH(5),  .SEL_W(3)) small_if ();

  mux_scan_sequencer #(.NUM_CH(20), .SEL_W(5), .SETTLE(2)) dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (big_if.master)
  );

  mux_scan_sequencer #(.NUM_CH(5), .SEL_W(3), .SETTLE(1)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (small_if.master)
  );

  // Behavioural select muxes.
  always_comb begin
    big_if.mux_in = 1'b0;
    if (big_if.mux_sel < 5'd20) big_if.mux_in = sig_big[big_if.mux_sel];
  end

  always_comb begin
    small_if.mux_in = 1'b0;
    if (small_if.mux_sel < 3'd5) small_if.mux_in = sig_small[small_if.mux_sel];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    big_if.start = 1'b1;
    small_if.start = 1'b1;
    tick(3);
    checks++;
    if (big_if.mux_sel !== 5'd0) begin
      errors++; $display("FAIL reset_sel got=%0d exp=0", big_if.mux_sel);
    end
    checks++;
    if (big_if.frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", big_if.frame_valid);
    end
    checks++;
    if (big_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", big_if.busy);
    end
    checks++;
    if (big_if.frame_data !== 20'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=00000", big_if.frame_data);
    end
    checks++;
    if (small_if.busy !== 1'b0 || small_if.frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_small got busy=%b valid=%b exp 0/0", small_if.busy, small_if.frame_valid);
    end
    reset = 1'b0;
    big_if.start = 1'b0;
    small_if.start = 1'b0;
    tick(1);
    checks++;
    if (big_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored busy got=%b exp=0", big_if.busy);
    end
  endtask

  task automatic test_single_shot;
    logic [4:0] exp_sel;
    sig_big = 20'hA5C3F;
    big_if.frame_ready = 1'b1;
    big_if.continuous = 1'b0;
    big_if.start = 1'b1;
    tick(1);                          // edge 0
    big_if.start = 1'b0;
    for (int e = 0; e < 60; e++) begin
      exp_sel = 5'(e / 3);
      checks++;
      if (big_if.mux_sel !== exp_sel || big_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_sel edge=%0d got sel=%0d busy=%b exp sel=%0d busy=1", e, big_if.mux_sel, big_if.busy, exp_sel);
      end
      tick(1);
    end
    // now after edge 60: DELIVER, frame not yet loaded
    checks++;
    if (big_if.frame_valid !== 1'b0 || big_if.mux_sel !== 5'd19) begin
      errors++; $display("FAIL single_edge60 got valid=%b sel=%0d exp valid=0 sel=19", big_if.frame_valid, big_if.mux_sel);
    end
    tick(1);                          // edge 61
    checks++;
    if (big_if.frame_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got=%b exp=1", big_if.frame_valid);
    end
    checks++;
    if (big_if.frame_data !== 20'hA5C3F) begin
      errors++; $display("FAIL single_data got=%h exp=a5c3f", big_if.frame_data);
    end
    checks++;
    if (big_if.busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_fall got=%b exp=0", big_if.busy);
    end
    tick(1);                          // edge 62: consumed
    checks++;
    if (big_if.frame_valid !== 1'b0) begin
      errors++; $display("FAIL single_consume got valid=%b exp=0", big_if.frame_valid);
    end
  endtask

  task automatic test_continuous_stall;
    sig_big = 20'h12345;
    big_if.frame_ready = 1'b0;
    big_if.continuous = 1'b1;
    big_if.start = 1'b1;
    tick(1);                          // edge 0
    big_if.start = 1'b0;
    tick(61);                         // edge 61
    checks++;
    if (big_if.frame_valid !== 1'b1 || big_if.frame_data !== 20'h12345) begin
      errors++; $display("FAIL cont_frame1 got valid=%b data=%h exp 1/12345", big_if.frame_valid, big_if.frame_data);
    end
    checks++;
    if (big_if.busy !== 1'b1 || big_if.mux_sel !== 5'd0) begin
      errors++; $display("FAIL cont_restart got busy=%b sel=%0d exp 1/0", big_if.busy, big_if.mux_sel);
    end
    sig_big = 20'hABCDE;
    tick(64);                         // edge 125: frame 2 stalled in DELIVER
    checks++;
    if (big_if.mux_sel !== 5'd19 || big_if.busy !== 1'b1) begin
      errors++; $display("FAIL cont_stall_sel got sel=%0d busy=%b exp 19/1", big_if.mux_sel, big_if.busy);
    end
    checks++;
    if (big_if.frame_valid !== 1'b1 || big_if.frame_data !== 20'h12345) begin
      errors++; $display("FAIL cont_stall_data got valid=%b data=%h exp 1/12345", big_if.frame_valid, big_if.frame_data);
    end
    big_if.frame_ready = 1'b1;
    tick(1);                          // edge 126: consume + load same edge
    big_if.frame_ready = 1'b0;
    checks++;
    if (big_if.frame_valid !== 1'b1 || big_if.frame_data !== 20'hABCDE) begin
      errors++; $display("FAIL cont_load_wins got valid=%b data=%h exp 1/abcde", big_if.frame_valid, big_if.frame_data);
    end
    checks++;
    if (big_if.mux_sel !== 5'd0 || big_if.busy !== 1'b1) begin
      errors++; $display("FAIL cont_rescan got sel=%0d busy=%b exp 0/1", big_if.mux_sel, big_if.busy);
    end
    tick(2);
    checks++;
    if (big_if.frame_data !== 20'hABCDE || big_if.frame_valid !== 1'b1) begin
      errors++; $display("FAIL cont_hold got valid=%b data=%h exp 1/abcde", big_if.frame_valid, big_if.frame_data);
    end
    big_if.continuous = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    sig_big = 20'hFFFFF;
    big_if.frame_ready = 1'b1;
    big_if.start = 1'b1;
    tick(1);                          // edge 0
    big_if.start = 1'b0;
    tick(21);                         // edge 21
    checks++;
    if (big_if.mux_sel !== 5'd7) begin
      errors++; $display("FAIL midrst_pre got sel=%0d exp=7", big_if.mux_sel);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (big_if.mux_sel !== 5'd0 || big_if.busy !== 1'b0 || big_if.frame_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state got sel=%0d busy=%b valid=%b exp 0/0/0", big_if.mux_sel, big_if.busy, big_if.frame_valid);
    end
    tick(70);
    checks++;
    if (big_if.frame_valid !== 1'b0 || big_if.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_noframe got valid=%b busy=%b exp 0/0", big_if.frame_valid, big_if.busy);
    end
  endtask

  task automatic test_start_while_busy;
    sig_big = 20'h5A5A5;
    big_if.frame_ready = 1'b1;
    big_if.continuous = 1'b0;
    big_if.start = 1'b1;
    tick(1);                          // edge 0
    big_if.start = 1'b0;
    tick(12);                         // edge 12, sel=4
    big_if.start = 1'b1;
    tick(1);                          // edge 13
    big_if.start = 1'b0;
    checks++;
    if (big_if.mux_sel !== 5'd4) begin
      errors++; $display("FAIL busy_start_sel13 got sel=%0d exp=4", big_if.mux_sel);
    end
    tick(2);                          // edge 15
    checks++;
    if (big_if.mux_sel !== 5'd5) begin
      errors++; $display("FAIL busy_start_sel15 got sel=%0d exp=5", big_if.mux_sel);
    end
    tick(45);                         // edge 60
    checks++;
    if (big_if.frame_valid !== 1'b0) begin
      errors++; $display("FAIL busy_start_early got valid=%b exp=0", big_if.frame_valid);
    end
    tick(1);                          // edge 61
    checks++;
    if (big_if.frame_valid !== 1'b1 || big_if.frame_data !== 20'h5A5A5 || big_if.busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_frame got valid=%b data=%h busy=%b exp 1/5a5a5/0", big_if.frame_valid, big_if.frame_data, big_if.busy);
    end
    tick(1);
  endtask

  task automatic test_small_config;
    logic [2:0] exp_sel;
    sig_small = 5'b10110;
    small_if.frame_ready = 1'b1;
    small_if.continuous = 1'b0;
    small_if.start = 1'b1;
    tick(1);                          // edge 0
    small_if.start = 1'b0;
    for (int e = 0; e < 10; e++) begin
      exp_sel = 3'(e / 2);
      checks++;
      if (small_if.mux_sel !== exp_sel) begin
        errors++; $display("FAIL small_sel edge=%0d got=%0d exp=%0d", e, small_if.mux_sel, exp_sel);
      end
      tick(1);
    end
    // edge 10
    checks++;
    if (small_if.frame_valid !== 1'b0 || small_if.mux_sel !== 3'd4) begin
      errors++; $display("FAIL small_edge10 got valid=%b sel=%0d exp 0/4", small_if.frame_valid, small_if.mux_sel);
    end
    tick(1);                          // edge 11
    checks++;
    if (small_if.frame_valid !== 1'b1 || small_if.frame_data !== 5'b10110 || small_if.busy !== 1'b0) begin
      errors++; $display("FAIL small_frame got valid=%b data=%b busy=%b exp 1/10110/0", small_if.frame_valid, small_if.frame_data, small_if.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    sig_big = '0;
    sig_small = '0;
    big_if.start = 1'b0;
    big_if.continuous = 1'b0;
    big_if.frame_ready = 1'b0;
    small_if.start = 1'b0;
    small_if.continuous = 1'b0;
    small_if.frame_ready = 1'b0;
    test_reset();
    test_single_shot();
    test_continuous_stall();
    test_reset_mid_scan();
    test_start_while_busy();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
